// File: rtl/unified_mem_arbiter.sv
// Arbiter for the single-ported unified instruction/data memory. It issues one op per clk, gives data
// priority, and forces a fetch after a data streak. Define MEM_ARB_PERF_EN to build the wait-cycle counters.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int MAX_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [1:0]        d_size,
  input  logic              d_signed,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        mem_size,
  output logic              mem_signed,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       if_wait_cnt,
  output logic [31:0]       d_wait_cnt
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {TAG_NONE, TAG_IF, TAG_D} tag_t;

  tag_t                tag_q, tag_d;
  logic [STREAK_W-1:0] streak_q;
  logic                force_if;

  // Data normally wins so the older instruction drains first; fetch gets one forced slot after a full streak.
  assign force_if = if_req && (streak_q == STREAK_W'(MAX_STREAK));
  assign d_gnt    = d_req && !force_if;
  assign if_gnt   = if_req && !d_gnt;

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    mem_addr   = '0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_wdata  = '0;
    mem_size   = 2'b00;
    mem_signed = 1'b0;
    if (d_gnt) begin
      mem_addr   = d_addr;
      mem_rd     = !d_we;
      mem_wr     = d_we;
      mem_wdata  = d_wdata;
      mem_size   = d_size;
      mem_signed = d_signed;
    end else if (if_gnt) begin
      mem_addr   = if_addr;
      mem_rd     = 1'b1;
      mem_size   = 2'b10;
    end
  end

  // The tag records who owns the read data that the memory returns next cycle; stores never own a response.
  always_comb begin
    tag_d = TAG_NONE;
    if (if_gnt && !if_flush) begin
      tag_d = TAG_IF;
    end else if (d_gnt && !d_we) begin
      tag_d = TAG_D;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      tag_q <= TAG_NONE;
    end else begin
      tag_q <= tag_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else if (if_gnt || !if_req) begin
      streak_q <= '0;
    end else if (d_gnt && (streak_q != STREAK_W'(MAX_STREAK))) begin
      streak_q <= streak_q + 1'b1;
    end
  end

  // A flush in the response cycle still kills a fetch that was issued before the redirect.
  assign if_rvalid = (tag_q == TAG_IF) && !if_flush;
  assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
  assign d_rvalid  = (tag_q == TAG_D);
  assign d_rdata   = d_rvalid ? mem_rdata : 32'd0;

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_wait_cnt <= 32'd0;
      d_wait_cnt  <= 32'd0;
    end else begin
      if (if_req && !if_gnt && (if_wait_cnt != 32'hFFFF_FFFF)) begin
        if_wait_cnt <= if_wait_cnt + 32'd1;
      end
      if (d_req && !d_gnt && (d_wait_cnt != 32'hFFFF_FFFF)) begin
        d_wait_cnt <= d_wait_cnt + 32'd1;
      end
    end
  end
`else
  assign if_wait_cnt = 32'd0;
  assign d_wait_cnt  = 32'd0;
`endif

endmodule
